// File: rtl/branch_resolve_unit_if.sv
// Decode/EX-facing signal bundle for branch_resolve_unit.
// The master side issues pushes and resolves; the slave side reports updates, flushes and status.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 16
);
    logic             push_en;
    logic [31:0]      push_pc;
    logic             push_pred_taken;
    logic [31:0]      push_pred_target;
    logic             res_en;
    logic [31:0]      res_pc;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             upd_br;
    logic             upd_taken;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             full;
    logic             empty;
    logic             err;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output push_en, push_pc, push_pred_taken, push_pred_target,
        output res_en, res_pc, res_taken, res_target,
        input  flush, redirect_pc, upd_br, upd_taken, upd_pc, upd_target,
        input  full, empty, err, br_count, miss_count
    );

    modport slave (
        input  push_en, push_pc, push_pred_taken, push_pred_target,
        input  res_en, res_pc, res_taken, res_target,
        output flush, redirect_pc, upd_br, upd_taken, upd_pc, upd_target,
        output full, empty, err, br_count, miss_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Tracks decode-time branch predictions in an in-order FIFO, checks them against EX outcomes,
// and issues flush/redirect plus predictor update strobes and saturating perf counters.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic                 CLK,
    input logic                 nRST,
    branch_resolve_unit_if.slave bif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];

    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    logic             full;
    logic             empty;
    logic             res_valid;
    logic             pc_mismatch;
    logic             dir_mismatch;
    logic             tgt_mismatch;
    logic             mispredict;
    logic             push_ok;
    logic             err_set;

    logic             err_q;
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] miss_q;
    logic             upd_br_q;
    logic             upd_taken_q;
    logic [31:0]      upd_pc_q;
    logic [31:0]      upd_target_q;
    logic             flush_q;
    logic [31:0]      redirect_q;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        res_valid    = bif.res_en && !empty;
        pc_mismatch  = (bif.res_pc != pc_mem[head_q]);
        dir_mismatch = (bif.res_taken != taken_mem[head_q]);
        tgt_mismatch = bif.res_taken && taken_mem[head_q] &&
                       (bif.res_target != target_mem[head_q]);
        mispredict   = res_valid && (pc_mismatch || dir_mismatch || tgt_mismatch);
        // A correct resolve frees the head slot in the same edge, so a push while full still fits;
        // a mispredict wipes the FIFO, so a same-cycle push is wrong-path and silently dropped.
        push_ok      = bif.push_en && !mispredict && (!full || res_valid);
        err_set      = (bif.push_en && full && !res_valid) ||
                       (bif.res_en && empty) ||
                       (res_valid && pc_mismatch);
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !res_valid) begin
            count_d = count_q + 1'b1;
        end else if (res_valid && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (mispredict) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (res_valid) begin
                head_q <= head_q + 1'b1;
            end
            if (push_ok) begin
                tail_q <= tail_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            pc_mem[tail_q]     <= bif.push_pc;
            taken_mem[tail_q]  <= bif.push_pred_taken;
            target_mem[tail_q] <= bif.push_pred_target;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q  <= 1'b0;
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (res_valid && (br_q != '1)) begin
                br_q <= br_q + 1'b1;
            end
            if (mispredict && (miss_q != '1)) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            upd_br_q     <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
        end else begin
            upd_br_q     <= res_valid;
            upd_taken_q  <= res_valid && bif.res_taken;
            upd_pc_q     <= res_valid ? bif.res_pc : '0;
            upd_target_q <= res_valid ? bif.res_target : '0;
            flush_q      <= mispredict;
            if (mispredict) begin
                redirect_q <= bif.res_taken ? bif.res_target : (bif.res_pc + 32'd4);
            end else begin
                redirect_q <= '0;
            end
        end
    end

    assign bif.full        = full;
    assign bif.empty       = empty;
    assign bif.err         = err_q;
    assign bif.br_count    = br_q;
    assign bif.miss_count  = miss_q;
    assign bif.upd_br      = upd_br_q;
    assign bif.upd_taken   = upd_taken_q;
    assign bif.upd_pc      = upd_pc_q;
    assign bif.upd_target  = upd_target_q;
    assign bif.flush       = flush_q;
    assign bif.redirect_pc = redirect_q;
endmodule
